uart: RTL and testbench

Memory-mapped 8N1 UART slave on the CPU data bus, decoded by the SoC address decoder alongside the GPIO block (suggested window 0xF000_1xxx). It has an 8-entry transmit FIFO, a single-byte receive buffer with overrun detection, a programmable baud divisor, and a level interrupt. The interrupt is intended to drive one bit of the CPU `irq` vector.

---
 rtl/uart.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_uart.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// Memory-mapped 8N1 UART slave with an 8-entry TX FIFO, single-byte RX buffer,
// programmable baud divisor and a registered level interrupt.
//
// Ports:
//   clk, reset_          single clock, synchronous active-low reset
//   mem_cmd_*            bus command (accepted on valid & sel, never stalls)
//   mem_rsp_ready/rdata  read response, one cycle after the accepted read
//   uart_txd / uart_rxd  serial line (txd idles high, rxd is asynchronous)
//   irq                  level interrupt
module uart #(
  parameter int unsigned TX_FIFO_DEPTH   = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        mem_cmd_sel,
  input  logic        mem_cmd_valid,
  input  logic        mem_cmd_wr,
  input  logic [11:0] mem_cmd_addr,
  input  logic [31:0] mem_cmd_wdata,
  output logic        mem_rsp_ready,
  output logic [31:0] mem_rsp_rdata,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        irq
);
  localparam int unsigned AW = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Bus decode
  logic       cmd, rd_cmd, wr_cmd, data_wr, data_rd, stat_wr;
  logic [1:0] reg_sel;
  assign cmd     = mem_cmd_valid & mem_cmd_sel;
  assign rd_cmd  = cmd & ~mem_cmd_wr;
  assign wr_cmd  = cmd & mem_cmd_wr;
  assign reg_sel = mem_cmd_addr[3:2];
  assign data_wr = wr_cmd & (reg_sel == 2'd0);
  assign data_rd = rd_cmd & (reg_sel == 2'd0);
  assign stat_wr = wr_cmd & (reg_sel == 2'd1);

  logic unused_bits;
  assign unused_bits = ^{mem_cmd_addr[11:4], mem_cmd_addr[1:0], mem_cmd_wdata[31:16]};

  logic [15:0] divisor_q, eff_div;
  logic [1:0]  ier_q;
  logic        rx_valid_q, rx_ovr_q, tx_ovf_q, frame_err_q, irq_q;
  logic [7:0]  rx_data_q;
  logic        rsp_ready_q;
  logic [31:0] rsp_rdata_q, rd_word;

  assign eff_div = (divisor_q < 16'd2) ? 16'd2 : divisor_q;

  // TX FIFO: pointers carry one extra bit so full and empty are distinguishable
  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic [LW-1:0] wr_ptr_q, rd_ptr_q, level;
  logic          tx_full, tx_empty, push, tx_pop;
  assign level    = wr_ptr_q - rd_ptr_q;
  assign tx_full  = (level == LW'(TX_FIFO_DEPTH));
  assign tx_empty = (level == '0);
  // Full is judged before any same-cycle pop, so a write to a full FIFO always drops
  assign push     = data_wr & ~tx_full;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + LW'(1);
      if (tx_pop) rd_ptr_q <= rd_ptr_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= mem_cmd_wdata[7:0];
  end

  // TX FSM. Bit counters load eff_div-1 at each bit start, so a divisor write
  // only affects the next bit.
  state_e      tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d, tx_busy;
  assign tx_busy = (tx_state_q != StIdle);

  always_ff @(posedge clk) begin
    if (!reset_) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      StIdle: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q[AW-1:0]];
          tx_cnt_d   = eff_div - 16'd1;
          tx_state_d = StStart;
          txd_d      = 1'b0;
        end
      end
      StStart: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = StData;
          tx_idx_d   = '0;
          tx_cnt_d   = eff_div - 16'd1;
          txd_d      = tx_shift_q[0];
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      StData: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = eff_div - 16'd1;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = StStop;
            txd_d      = 1'b1;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      StStop: begin
        if (tx_cnt_q == '0) begin
          if (!tx_empty) begin
            // Chain straight into the next start bit, no idle gap
            tx_pop     = 1'b1;
            tx_shift_d = fifo_mem[rd_ptr_q[AW-1:0]];
            tx_cnt_d   = eff_div - 16'd1;
            tx_state_d = StStart;
            txd_d      = 1'b0;
          end else tx_state_d = StIdle;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_state_d = StIdle;
    endcase
  end

  // RX path: 2-flop synchronizer plus one more flop for falling-edge detection
  logic        rx_s1_q, rx_s2_q, rx_last_q;
  state_e      rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_done, rx_ferr;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_last_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q    <= uart_rxd;
      rx_s2_q    <= rx_s1_q;
      rx_last_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // After a framing error the FSM returns to idle at once; a new frame still
  // needs a falling edge, which implies the line has gone back to 1 first.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        if (rx_last_q && !rx_s2_q) begin
          rx_state_d = StStart;
          rx_cnt_d   = (eff_div >> 1) - 16'd1;
        end
      end
      StStart: begin
        if (rx_cnt_q == '0) begin
          if (rx_s2_q) rx_state_d = StIdle;  // glitch
          else begin
            rx_state_d = StData;
            rx_idx_d   = '0;
            rx_cnt_d   = eff_div - 16'd1;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      StData: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = eff_div - 16'd1;
          if (rx_idx_q == 3'd7) rx_state_d = StStop;
          else rx_idx_d = rx_idx_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      StStop: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = StIdle;
          if (rx_s2_q) rx_done = 1'b1;
          else rx_ferr = 1'b1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // Register read mux, sampled at the command edge
  always_comb begin
    rd_word = '0;
    unique case (reg_sel)
      2'd0: rd_word = {23'b0, rx_valid_q, rx_data_q};
      2'd1: begin
        rd_word[0]        = tx_full;
        rd_word[1]        = tx_empty;
        rd_word[2]        = tx_busy;
        rd_word[3]        = rx_valid_q;
        rd_word[4]        = rx_ovr_q;
        rd_word[5]        = tx_ovf_q;
        rd_word[6]        = frame_err_q;
        rd_word[8 +: LW]  = level;
      end
      2'd2: rd_word = {16'b0, divisor_q};
      2'd3: rd_word = {30'b0, ier_q};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      divisor_q   <= DEFAULT_DIVISOR;
      ier_q       <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_ovr_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
      rsp_ready_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (wr_cmd && reg_sel == 2'd2) divisor_q <= mem_cmd_wdata[15:0];
      if (wr_cmd && reg_sel == 2'd3) ier_q <= mem_cmd_wdata[1:0];
      // A byte landing with a DATA read keeps valid set and is not an overrun
      if (rx_done) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= rx_shift_q;
      end else if (data_rd) rx_valid_q <= 1'b0;
      if (rx_done && rx_valid_q && !data_rd) rx_ovr_q <= 1'b1;
      else if (stat_wr && mem_cmd_wdata[4]) rx_ovr_q <= 1'b0;
      if (data_wr && tx_full) tx_ovf_q <= 1'b1;
      else if (stat_wr && mem_cmd_wdata[5]) tx_ovf_q <= 1'b0;
      if (rx_ferr) frame_err_q <= 1'b1;
      else if (stat_wr && mem_cmd_wdata[6]) frame_err_q <= 1'b0;
      irq_q       <= (rx_valid_q & ier_q[0]) | (tx_empty & ~tx_busy & ier_q[1]);
      rsp_ready_q <= rd_cmd;
      rsp_rdata_q <= rd_cmd ? rd_word : '0;
    end
  end

  assign mem_rsp_ready = rsp_ready_q;
  assign mem_rsp_rdata = rsp_rdata_q;
  assign uart_txd      = txd_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: randomized TX/RX traffic against a frame-level
// model of the serial line and a byte-level model of the receive buffer.
module tb_uart;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        sel = 1'b0, valid = 1'b0, wr = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        txd, irq;
  logic        rxd = 1'b1;

  int checks = 0;
  int errors = 0;

  // txd_log[i] is uart_txd just after the i-th (0-based) rising edge
  logic txd_log[$];

  uart #(.TX_FIFO_DEPTH(DEPTH), .DEFAULT_DIVISOR(16'd434)) dut (
    .clk          (clk),
    .reset_       (reset_),
    .mem_cmd_sel  (sel),
    .mem_cmd_valid(valid),
    .mem_cmd_wr   (wr),
    .mem_cmd_addr (addr),
    .mem_cmd_wdata(wdata),
    .mem_rsp_ready(rsp_ready),
    .mem_rsp_rdata(rsp_rdata),
    .uart_txd     (txd),
    .uart_rxd     (rxd),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    txd_log.push_back(txd);
  end

  // Line model: value of txd k cycles after the first start bit for a run of
  // back-to-back 8N1 frames; idle (1) outside the run.
  function automatic logic expected_txd(input logic [7:0] q[$], input int div, input int k);
    int flen, f, b;
    flen = 10 * div;
    if (k < 0 || k >= flen * q.size()) return 1'b1;
    f = k / flen;
    b = (k % flen) / div;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return q[f][b-1];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; valid = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; valid = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic r, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; valid = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0; valid = 1'b0;
    r = rsp_ready;
    d = rsp_rdata;
  endtask

  task automatic send_rx(input logic [7:0] b, input int div, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = f[i];
      repeat (div - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd = 1'b1;
    idle(4);
  endtask

  task automatic test_reset;
    logic r; logic [31:0] d;
    reset_ = 1'b0;
    idle(3);
    checks++;
    if (txd !== 1'b1 || rsp_ready !== 1'b0 || rsp_rdata !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: txd=%b ready=%b rdata=%h irq=%b, want 1 0 0 0",
               txd, rsp_ready, rsp_rdata, irq);
    end
    reset_ = 1'b1;
    bus_read(12'h4, r, d);
    checks++;
    if (r !== 1'b1 || d !== 32'h2) begin
      errors++; $display("FAIL reset_status: ready=%b got %h want 00000002", r, d);
    end
    bus_read(12'h8, r, d);
    checks++;
    if (d !== 32'd434) begin errors++; $display("FAIL reset_divisor: got %0d want 434", d); end
    bus_read(12'hC, r, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_ier: got %h want 0", d); end
    bus_read(12'h0, r, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", d); end
  endtask

  task automatic test_registers;
    logic r; logic [31:0] d;
    logic [15:0] v;
    for (int i = 0; i < 3; i++) begin
      v = 16'($urandom);
      bus_write(12'h8, {16'($urandom), v});
      bus_read(12'h8, r, d);
      checks++;
      if (d !== {16'h0, v}) begin errors++; $display("FAIL divisor_rw: got %h want %h", d, v); end
    end
    // Writes produce no response
    bus_write(12'hC, 32'hFFFF_FFFE);
    checks++;
    if (rsp_ready !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL write_no_rsp: ready=%b rdata=%h want 0 0", rsp_ready, rsp_rdata);
    end
    // Back-to-back reads: DIVISOR then IER on consecutive cycles
    @(negedge clk);
    sel = 1'b1; valid = 1'b1; wr = 1'b0; addr = 12'h8;
    @(negedge clk);
    addr = 12'hC;
    checks++;
    if (rsp_ready !== 1'b1 || rsp_rdata !== {16'h0, v}) begin
      errors++; $display("FAIL b2b_read0: ready=%b got %h want 1 %h", rsp_ready, rsp_rdata, v);
    end
    @(negedge clk);
    sel = 1'b0; valid = 1'b0;
    checks++;
    if (rsp_ready !== 1'b1 || rsp_rdata !== 32'h2) begin
      errors++; $display("FAIL b2b_read1: ready=%b got %h want 1 2", rsp_ready, rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if (rsp_ready !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL b2b_idle: ready=%b rdata=%h want 0 0", rsp_ready, rsp_rdata);
    end
    bus_write(12'hC, 32'h0);
  endtask

  task automatic test_tx_single;
    logic r; logic [31:0] d; logic e;
    logic [7:0] q[$];
    int base;
    q.delete(); q.push_back(8'h55);
    bus_write(12'h8, 32'd4);
    bus_write(12'h0, 32'h55);
    base = txd_log.size() - 1;
    idle(46);
    for (int k = -1; k <= 40; k++) begin
      e = expected_txd(q, 4, k);
      checks++;
      if (txd_log[base + 1 + k] !== e) begin
        errors++;
        $display("FAIL tx_single cycle %0d: got %b want %b", k, txd_log[base + 1 + k], e);
      end
    end
    bus_read(12'h4, r, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL tx_single_status: got %h want 2", d); end
  endtask

  task automatic test_tx_random;
    logic e;
    logic [7:0] q[$];
    int base, dv, eff, n, len;
    for (int round = 0; round < 4; round++) begin
      dv  = (round == 0) ? 0 : int'($urandom_range(1, 6));
      eff = (dv < 2) ? 2 : dv;
      n   = $urandom_range(1, DEPTH);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      bus_write(12'h8, dv);
      bus_write(12'h0, {24'h0, q[0]});
      base = txd_log.size() - 1;
      for (int i = 1; i < n; i++) bus_write(12'h0, {24'($urandom), q[i]});
      len = 10 * eff * n;
      idle(len + 4);
      for (int k = -1; k <= len; k++) begin
        e = expected_txd(q, eff, k);
        checks++;
        if (txd_log[base + 1 + k] !== e) begin
          errors++;
          $display("FAIL tx_random div=%0d cycle %0d: got %b want %b",
                   dv, k, txd_log[base + 1 + k], e);
        end
      end
    end
  endtask

  task automatic test_fifo_overflow;
    logic r; logic [31:0] d; logic e;
    logic [7:0] acc[$];
    int base, occ, len;
    // Occupancy model: the transmitter takes the first byte on the second command edge
    occ = 0;
    acc.delete();
    for (int i = 0; i < 10; i++) begin
      if (occ < DEPTH) begin acc.push_back(8'(i)); occ++; end
      if (i == 1) occ--;
    end
    bus_write(12'h8, 32'd100);
    @(negedge clk);
    base = txd_log.size();
    sel = 1'b1; valid = 1'b1; wr = 1'b1; addr = 12'h0;
    for (int i = 0; i < 10; i++) begin
      wdata = i;
      @(negedge clk);
    end
    sel = 1'b0; valid = 1'b0; wr = 1'b0;
    bus_read(12'h4, r, d);
    checks++;
    if (d !== ((occ << 8) | 32'h25)) begin
      errors++; $display("FAIL ovf_status: got %h want %h", d, (occ << 8) | 32'h25);
    end
    len = 1000 * acc.size();
    idle(len + 4);
    for (int k = -1; k <= len; k++) begin
      e = expected_txd(acc, 100, k);
      checks++;
      if (txd_log[base + 1 + k] !== e) begin
        errors++;
        $display("FAIL ovf_serial cycle %0d: got %b want %b", k, txd_log[base + 1 + k], e);
      end
    end
    bus_read(12'h4, r, d);
    checks++;
    if (d !== 32'h22) begin errors++; $display("FAIL ovf_sticky: got %h want 22", d); end
    bus_write(12'h4, 32'h20);
    bus_read(12'h4, r, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL ovf_clear: got %h want 2", d); end
  endtask

  task automatic test_rx_byte;
    logic r; logic [31:0] d;
    bus_write(12'h8, 32'd8);
    bus_write(12'hC, 32'd1);
    send_rx(8'hA3, 8, 1'b1);
    bus_read(12'h4, r, d);
    checks++;
    if (d !== 32'h0A) begin errors++; $display("FAIL rx_status: got %h want 0a", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq: got %b want 1", irq); end
    bus_read(12'h0, r, d);
    checks++;
    if (r !== 1'b1 || d !== 32'h1A3) begin
      errors++; $display("FAIL rx_read1: ready=%b got %h want 1 1a3", r, d);
    end
    bus_read(12'h0, r, d);
    checks++;
    if (d !== 32'h0A3) begin errors++; $display("FAIL rx_read2: got %h want 0a3", d); end
    idle(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_rx_random;
    logic r; logic [31:0] d;
    logic       m_valid, m_ovr;
    logic [7:0] m_data, b;
    m_valid = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send_rx(b, 8, 1'b1);
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = b;
      checks++;
      if (irq !== m_valid) begin errors++; $display("FAIL rxr_irq: got %b want %b", irq, m_valid); end
      bus_read(12'h4, r, d);
      checks++;
      if (d !== (32'h2 | (32'(m_valid) << 3) | (32'(m_ovr) << 4))) begin
        errors++;
        $display("FAIL rxr_status iter %0d: got %h want %h", i, d,
                 32'h2 | (32'(m_valid) << 3) | (32'(m_ovr) << 4));
      end
      if ($urandom_range(0, 1) == 1) begin
        bus_read(12'h0, r, d);
        checks++;
        if (d !== {23'h0, m_valid, m_data}) begin
          errors++; $display("FAIL rxr_data iter %0d: got %h want %h", i, d, {m_valid, m_data});
        end
        m_valid = 1'b0;
      end
    end
    bus_read(12'h0, r, d);
    bus_write(12'h4, 32'h70);
    bus_read(12'h4, r, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL rxr_clear: got %h want 2", d); end
  endtask

  task automatic test_rx_errors;
    logic r; logic [31:0] d;
    send_rx(8'h11, 8, 1'b1);
    send_rx(8'h22, 8, 1'b1);
    bus_read(12'h4, r, d);
    checks++;
    if (d !== 32'h1A) begin errors++; $display("FAIL overrun_status: got %h want 1a", d); end
    send_rx(8'h33, 8, 1'b0);
    bus_read(12'h4, r, d);
    checks++;
    if (d !== 32'h5A) begin errors++; $display("FAIL frame_status: got %h want 5a", d); end
    bus_read(12'h0, r, d);
    checks++;
    if (d !== 32'h122) begin errors++; $display("FAIL frame_data: got %h want 122", d); end
    @(negedge clk); rxd = 1'b0;
    @(negedge clk); rxd = 1'b1;
    idle(40);
    bus_read(12'h4, r, d);
    checks++;
    if (d !== 32'h52) begin errors++; $display("FAIL glitch_status: got %h want 52", d); end
    bus_read(12'h0, r, d);
    checks++;
    if (d !== 32'h022) begin errors++; $display("FAIL glitch_data: got %h want 022", d); end
    bus_write(12'h4, 32'h70);
    bus_read(12'h4, r, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL err_clear: got %h want 2", d); end
  endtask

  task automatic test_irq_tx;
    bus_write(12'hC, 32'd2);
    idle(2);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_idle: got %b want 1", irq); end
    bus_write(12'h8, 32'd4);
    bus_write(12'h0, 32'hC3);
    idle(5);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_tx_busy: got %b want 0", irq); end
    idle(45);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_done: got %b want 1", irq); end
    bus_write(12'hC, 32'd0);
    idle(2);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b want 0", irq); end
  endtask

  task automatic test_reset_mid_frame;
    logic r; logic [31:0] d;
    bus_write(12'h8, 32'd4);
    bus_write(12'hC, 32'd1);
    send_rx(8'h5A, 4, 1'b1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    for (int i = 0; i < 3; i++) bus_write(12'h0, 32'($urandom_range(0, 255)));
    idle(10);
    @(negedge clk); reset_ = 1'b0;
    @(negedge clk); reset_ = 1'b1;
    checks++;
    if (txd !== 1'b1 || irq !== 1'b0 || rsp_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_out: txd=%b irq=%b ready=%b want 1 0 0", txd, irq, rsp_ready);
    end
    bus_read(12'h4, r, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL midreset_status: got %h want 2", d); end
    bus_read(12'h8, r, d);
    checks++;
    if (d !== 32'd434) begin errors++; $display("FAIL midreset_div: got %0d want 434", d); end
    bus_read(12'h0, r, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h want 0", d); end
  endtask

  initial begin
    test_reset;
    test_registers;
    test_tx_single;
    test_tx_random;
    test_fifo_overflow;
    test_rx_byte;
    test_rx_random;
    test_rx_errors;
    test_irq_tx;
    test_reset_mid_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
